bin_to_bcd_seq: RTL

- Sequential binary-to-BCD encoder using the iterative shift-add-3 (double-dabble) method; the opposite direction of the team's BCD-to-decimal digit decoder.
- Accepts one WIDTH-bit binary value per transaction and returns DIGITS packed BCD digits after a fixed latency.
- Sits ahead of display/serial digit paths.
- Counts completed conversions and stops accepting new requests once MAX_CONV is reached, until reset.

---
 rtl/bin_to_bcd_seq.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: iterative shift-add-3 (double-dabble) binary-to-BCD encoder.
// Converts one WIDTH-bit value per transaction into DIGITS packed BCD digits.
// It takes WIDTH shift cycles, then one DONE cycle that publishes the result.
// The block stops accepting requests after MAX_CONV completed conversions.
// It accepts requests again only after reset.
// Optional macro BIN2BCD_CLAMP_EN: when defined, inputs above 10^DIGITS-1 are
// clamped to 10^DIGITS-1 and ovf is flagged. When undefined, the result is
// bin mod 10^DIGITS and ovf is tied low.
module bin_to_bcd_seq #(
  parameter int WIDTH    = 10,
  parameter int DIGITS   = 3,
  parameter int MAX_CONV = 300,
  parameter int CNT_W    = 9
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      bin,
  output logic                  out_valid,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf,
  output logic [CNT_W-1:0]      conv_count,
  output logic                  exhausted
);

  localparam int ACC_W = 4 * DIGITS;
  localparam int BIT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_CONV);
  localparam logic [BIT_W-1:0] BIT_INIT = BIT_W'(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  logic [WIDTH-1:0] shreg;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_adj;
  logic [BIT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] load_val;

  logic accept;
  logic shift_en;
  logic done_en;

  // State register; reset aborts any conversion in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: WIDTH shift cycles, then one DONE cycle
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = SHIFT;
      SHIFT:   if (bit_cnt == BIT_W'(1)) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Control outputs decoded from the registered state
  always_comb begin
    in_ready = (state == IDLE) && !exhausted;
    accept   = in_valid && in_ready;
    shift_en = (state == SHIFT);
    done_en  = (state == DONE);
  end

  // Add-3 correction: any digit of 5 or more is bumped before the doubling
  always_comb begin
    acc_adj = acc;
    for (int d = 0; d < DIGITS; d++) begin
      if (acc[4*d +: 4] >= 4'd5) begin
        acc_adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
      end
    end
  end

`ifdef BIN2BCD_CLAMP_EN
  localparam logic [31:0] DEC_MAX = 32'(10 ** DIGITS - 1);

  logic in_over;
  logic ovf_pend;

  // Saturate oversize inputs to the largest representable decimal value
  always_comb begin
    in_over  = 32'(bin) > DEC_MAX;
    load_val = in_over ? WIDTH'(DEC_MAX) : bin;
  end

  // Overflow flag captured at acceptance, published with that result
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_pend <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      if (accept) ovf_pend <= in_over;
      if (done_en) ovf <= ovf_pend;
    end
  end
`else
  // Without clamping the value goes in unchanged and wraps modulo 10^DIGITS
  always_comb begin
    load_val = bin;
  end

  assign ovf = 1'b0;
`endif

  // Datapath: load on acceptance, shift {acc, shreg} left, publish in DONE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg   <= '0;
      acc     <= '0;
      bit_cnt <= '0;
      bcd     <= '0;
    end else begin
      if (accept) begin
        shreg   <= load_val;
        acc     <= '0;
        bit_cnt <= BIT_INIT;
      end else if (shift_en) begin
        acc     <= {acc_adj[ACC_W-2:0], shreg[WIDTH-1]};
        shreg   <= {shreg[WIDTH-2:0], 1'b0};
        bit_cnt <= bit_cnt - BIT_W'(1);
      end
      if (done_en) begin
        bcd <= acc;
      end
    end
  end

  // One-cycle result strobe, aligned with the bcd update
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= done_en;
    end
  end

  // Saturating conversion budget; exhausted rises with the final increment
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      conv_count <= '0;
      exhausted  <= 1'b0;
    end else if (done_en && (conv_count < MAX_C)) begin
      conv_count <= conv_count + CNT_W'(1);
      exhausted  <= ((conv_count + CNT_W'(1)) == MAX_C);
    end
  end

endmodule
